// File: rtl/bcd_lap_digit.sv
// bcd_lap_digit
// One decade (or smaller modulus) of a cascadable stopwatch digit. It has a
// start/stop/lap state machine, an up/down counter with preset and a
// carry/borrow output, a lap-freeze register, and a registered seven-segment
// decoder.
//
// Parameters:
//   MODULUS        count modulus, 2..10
//   RESET_VAL      counter and lap value after reset, < MODULUS
//   SEG_ACTIVE_LOW 1 inverts the segment outputs
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   TICK      in   count enable (prescaler or lower digit CO)
//   UP        in   1 = count up, 0 = count down
//   SS        in   start/stop pulse
//   LAP       in   lap/clear pulse
//   LOAD      in   preset strobe
//   LOAD_VAL  in   preset value (clamped to MODULUS-1)
//   DIGIT     out  live counter value
//   CO        out  carry/borrow, combinational
//   RUNNING   out  high in RUN or LAP
//   a..g      out  registered seven-segment drive of the displayed value
module bcd_lap_digit #(
  parameter int MODULUS        = 10,
  parameter int RESET_VAL      = 0,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       UP,
  input  logic       SS,
  input  logic       LAP,
  input  logic       LOAD,
  input  logic [3:0] LOAD_VAL,
  output logic [3:0] DIGIT,
  output logic       CO,
  output logic       RUNNING,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  localparam logic [3:0] MAX_VAL = 4'(MODULUS - 1);
  localparam logic [3:0] RST_VAL = 4'(RESET_VAL);

  // The state names carry an S_ prefix because LAP is already a port name.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } stateType;

  stateType   state;
  stateType   stateNext;
  logic [3:0] count;
  logic [3:0] countNext;
  logic [3:0] lapReg;
  logic [3:0] display;
  logic [3:0] loadClamped;
  logic [6:0] segPattern;
  logic [6:0] segReg;
  logic       runningState;
  logic       clearToIdle;
  logic       enterLap;
  logic       atTerminal;

  // Segment patterns packed as {a,b,c,d,e,f,g}, active-high. Codes above 9
  // show a dash.
  function automatic logic [6:0] segDecode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'b1111110;
      4'd1:    pattern = 7'b0110000;
      4'd2:    pattern = 7'b1101101;
      4'd3:    pattern = 7'b1111001;
      4'd4:    pattern = 7'b0110011;
      4'd5:    pattern = 7'b1011011;
      4'd6:    pattern = 7'b1011111;
      4'd7:    pattern = 7'b1110000;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1111011;
      default: pattern = 7'b0000001;
    endcase
    return pattern;
  endfunction

  // Next-state logic. When SS and LAP arrive together, SS is tested first,
  // so LAP is ignored in that cycle.
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: if (SS) stateNext = S_RUN;
      S_RUN: begin
        if (SS)       stateNext = S_STOP;
        else if (LAP) stateNext = S_LAP;
      end
      S_LAP: begin
        if (SS)       stateNext = S_STOP;
        else if (LAP) stateNext = S_RUN;
      end
      S_STOP: begin
        if (SS)       stateNext = S_RUN;
        else if (LAP) stateNext = S_IDLE;
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Counter next value. LOAD wins over the clear-to-idle and over ticks.
  // The lap register samples this value, so a tick in the same cycle as
  // entry into LAP is included in the frozen value.
  always_comb begin
    runningState = (state == S_RUN) || (state == S_LAP);
    clearToIdle  = (state == S_STOP) && !SS && LAP;
    enterLap     = (state == S_RUN) && !SS && LAP;
    loadClamped  = ({1'b0, LOAD_VAL} >= 5'(MODULUS)) ? MAX_VAL : LOAD_VAL;
    atTerminal   = UP ? (count == MAX_VAL) : (count == 4'd0);
    countNext    = count;
    if (LOAD) begin
      countNext = loadClamped;
    end else if (clearToIdle) begin
      countNext = RST_VAL;
    end else if (runningState && TICK) begin
      if (UP) countNext = (count == MAX_VAL) ? 4'd0 : count + 4'd1;
      else    countNext = (count == 4'd0) ? MAX_VAL : count - 4'd1;
    end
  end

  // The display shows the frozen lap value while in LAP. The segment
  // pattern is decoded here and registered below.
  always_comb begin
    display    = (state == S_LAP) ? lapReg : count;
    segPattern = segDecode(display);
  end

  // Reset is gated into RUNNING and CO combinationally, so both outputs read
  // 0 during the reset cycle as well.
  always_comb begin
    RUNNING = runningState & ~RST;
    CO      = TICK & RUNNING & ~LOAD & atTerminal;
    DIGIT   = count;
    {a, b, c, d, e, f, g} = SEG_ACTIVE_LOW ? ~segReg : segReg;
  end

  // State, counter, lap and segment registers. A reset discards any frozen
  // lap value and preloads the segments with the decoded reset value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      count  <= RST_VAL;
      lapReg <= RST_VAL;
      segReg <= segDecode(RST_VAL);
    end else begin
      state  <= stateNext;
      count  <= countNext;
      segReg <= segPattern;
      if (enterLap) lapReg <= countNext;
    end
  end

endmodule

// File: tb/tb_bcd_lap_digit.sv
module tb_bcd_lap_digit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Digit with modulus 6
  logic       rst6, tick6, up6, ss6, lap6, load6;
  logic [3:0] loadVal6;
  logic [3:0] digit6;
  logic       co6, running6;
  logic       a6, b6, c6, d6, e6, f6, g6;
  logic [6:0] seg6;

  // Digit with modulus 10
  logic       rst10, tick10, up10, ss10, lap10, load10;
  logic [3:0] loadVal10;
  logic [3:0] digit10;
  logic       co10, running10;
  logic       a10, b10, c10, d10, e10, f10, g10;
  logic [6:0] seg10;

  int errors = 0;
  int checks = 0;

  assign seg6  = {a6, b6, c6, d6, e6, f6, g6};
  assign seg10 = {a10, b10, c10, d10, e10, f10, g10};

  bcd_lap_digit #(.MODULUS(6), .RESET_VAL(0), .SEG_ACTIVE_LOW(1'b0)) dut6 (
    .CLK(CLK), .RST(rst6), .TICK(tick6), .UP(up6), .SS(ss6), .LAP(lap6),
    .LOAD(load6), .LOAD_VAL(loadVal6), .DIGIT(digit6), .CO(co6),
    .RUNNING(running6), .a(a6), .b(b6), .c(c6), .d(d6), .e(e6), .f(f6), .g(g6)
  );

  bcd_lap_digit #(.MODULUS(10), .RESET_VAL(0), .SEG_ACTIVE_LOW(1'b0)) dut10 (
    .CLK(CLK), .RST(rst10), .TICK(tick10), .UP(up10), .SS(ss10), .LAP(lap10),
    .LOAD(load10), .LOAD_VAL(loadVal10), .DIGIT(digit10), .CO(co10),
    .RUNNING(running10), .a(a10), .b(b10), .c(c10), .d(d10), .e(e10), .f(f10), .g(g10)
  );

  // Advance one rising edge and settle
  task automatic waitEdge;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst6 = 1; tick6 = 1; ss6 = 1; lap6 = 1; load6 = 1; loadVal6 = 4'd3; up6 = 1;
    rst10 = 1; tick10 = 1; ss10 = 1; lap10 = 1; load10 = 1; loadVal10 = 4'd7; up10 = 1;
    #1;
    checks++; if (running6 !== 1'b0) begin errors++; $display("[TB] FAIL rst_running6_comb: got %b expected 0", running6); end
    checks++; if (co10 !== 1'b0) begin errors++; $display("[TB] FAIL rst_co10_comb: got %b expected 0", co10); end
    waitEdge;
    checks++; if (digit6 !== 4'd0) begin errors++; $display("[TB] FAIL rst_digit6: got %0d expected 0", digit6); end
    checks++; if (digit10 !== 4'd0) begin errors++; $display("[TB] FAIL rst_digit10: got %0d expected 0", digit10); end
    checks++; if (seg6 !== 7'h7E) begin errors++; $display("[TB] FAIL rst_seg6: got %h expected 7e", seg6); end
    checks++; if (seg10 !== 7'h7E) begin errors++; $display("[TB] FAIL rst_seg10: got %h expected 7e", seg10); end
    waitEdge;
    rst6 = 0; tick6 = 0; ss6 = 0; lap6 = 0; load6 = 0;
    rst10 = 0; tick10 = 0; ss10 = 0; lap10 = 0; load10 = 0;
    waitEdge;
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_running10: got %b expected 0", running10); end
    checks++; if (digit10 !== 4'd0) begin errors++; $display("[TB] FAIL rst_idle_digit10: got %0d expected 0", digit10); end
  endtask

  task automatic test_count_up_wrap;
    logic [3:0] expDigit [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    logic       expCo    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    up6 = 1; ss6 = 1;
    waitEdge;
    ss6 = 0;
    checks++; if (running6 !== 1'b1) begin errors++; $display("[TB] FAIL up_running6: got %b expected 1", running6); end
    for (int i = 0; i < 6; i++) begin
      tick6 = 1;
      #1;
      checks++; if (co6 !== expCo[i]) begin errors++; $display("[TB] FAIL up_co6 step %0d: got %b expected %b", i, co6, expCo[i]); end
      waitEdge;
      checks++; if (digit6 !== expDigit[i]) begin errors++; $display("[TB] FAIL up_digit6 step %0d: got %0d expected %0d", i, digit6, expDigit[i]); end
    end
    tick6 = 0;
  endtask

  task automatic test_count_down_wrap;
    up10 = 0; tick10 = 1;
    #1;
    checks++; if (co10 !== 1'b0) begin errors++; $display("[TB] FAIL down_idle_co10: got %b expected 0", co10); end
    waitEdge;
    checks++; if (digit10 !== 4'd0) begin errors++; $display("[TB] FAIL down_idle_digit10: got %0d expected 0", digit10); end
    tick10 = 0; ss10 = 1;
    waitEdge;
    ss10 = 0;
    checks++; if (running10 !== 1'b1) begin errors++; $display("[TB] FAIL down_running10: got %b expected 1", running10); end
    tick10 = 1;
    #1;
    checks++; if (co10 !== 1'b1) begin errors++; $display("[TB] FAIL down_borrow_co10: got %b expected 1", co10); end
    waitEdge;
    tick10 = 0;
    checks++; if (digit10 !== 4'd9) begin errors++; $display("[TB] FAIL down_wrap_digit10: got %0d expected 9", digit10); end
  endtask

  task automatic test_lap_freeze;
    load10 = 1; loadVal10 = 4'd3;
    waitEdge;
    load10 = 0;
    checks++; if (digit10 !== 4'd3) begin errors++; $display("[TB] FAIL lap_preload_digit10: got %0d expected 3", digit10); end
    checks++; if (running10 !== 1'b1) begin errors++; $display("[TB] FAIL lap_load_keeps_run: got %b expected 1", running10); end
    up10 = 1; lap10 = 1;
    waitEdge;
    lap10 = 0;
    checks++; if (running10 !== 1'b1) begin errors++; $display("[TB] FAIL lap_running10: got %b expected 1", running10); end
    tick10 = 1;
    repeat (4) waitEdge;
    tick10 = 0;
    checks++; if (digit10 !== 4'd7) begin errors++; $display("[TB] FAIL lap_live_digit10: got %0d expected 7", digit10); end
    checks++; if (seg10 !== 7'h79) begin errors++; $display("[TB] FAIL lap_frozen_seg10: got %h expected 79", seg10); end
    lap10 = 1;
    waitEdge;
    lap10 = 0;
    checks++; if (seg10 !== 7'h79) begin errors++; $display("[TB] FAIL lap_exit_seg10_hold: got %h expected 79", seg10); end
    waitEdge;
    checks++; if (seg10 !== 7'h70) begin errors++; $display("[TB] FAIL lap_exit_seg10_live: got %h expected 70", seg10); end
  endtask

  task automatic test_clear_priority;
    load10 = 1; loadVal10 = 4'd4;
    waitEdge;
    load10 = 0; ss10 = 1;
    waitEdge;
    ss10 = 0;
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL clr_stop_running10: got %b expected 0", running10); end
    tick10 = 1;
    waitEdge;
    tick10 = 0;
    checks++; if (digit10 !== 4'd4) begin errors++; $display("[TB] FAIL clr_stop_hold_digit10: got %0d expected 4", digit10); end
    ss10 = 1; lap10 = 1;
    waitEdge;
    ss10 = 0; lap10 = 0;
    checks++; if (running10 !== 1'b1) begin errors++; $display("[TB] FAIL clr_prio_running10: got %b expected 1", running10); end
    checks++; if (digit10 !== 4'd4) begin errors++; $display("[TB] FAIL clr_prio_digit10: got %0d expected 4", digit10); end
    ss10 = 1;
    waitEdge;
    ss10 = 0; lap10 = 1;
    waitEdge;
    lap10 = 0;
    checks++; if (digit10 !== 4'd0) begin errors++; $display("[TB] FAIL clr_idle_digit10: got %0d expected 0", digit10); end
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL clr_idle_running10: got %b expected 0", running10); end
    ss10 = 1;
    waitEdge;
    waitEdge;
    ss10 = 0; lap10 = 1; load10 = 1; loadVal10 = 4'd5;
    waitEdge;
    lap10 = 0; load10 = 0;
    checks++; if (digit10 !== 4'd5) begin errors++; $display("[TB] FAIL clr_load_wins_digit10: got %0d expected 5", digit10); end
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL clr_load_idle_running10: got %b expected 0", running10); end
  endtask

  task automatic test_load_clamp;
    load6 = 1; loadVal6 = 4'd5;
    waitEdge;
    load6 = 0;
    checks++; if (digit6 !== 4'd5) begin errors++; $display("[TB] FAIL clamp_preload_digit6: got %0d expected 5", digit6); end
    load6 = 1; loadVal6 = 4'd9; tick6 = 1; up6 = 1;
    #1;
    checks++; if (co6 !== 1'b0) begin errors++; $display("[TB] FAIL clamp_co6: got %b expected 0", co6); end
    waitEdge;
    load6 = 0; tick6 = 0;
    checks++; if (digit6 !== 4'd5) begin errors++; $display("[TB] FAIL clamp_digit6: got %0d expected 5", digit6); end
    checks++; if (running6 !== 1'b1) begin errors++; $display("[TB] FAIL clamp_running6: got %b expected 1", running6); end
  endtask

  task automatic test_reset_mid_lap;
    ss10 = 1;
    waitEdge;
    ss10 = 0; load10 = 1; loadVal10 = 4'd7;
    waitEdge;
    load10 = 0; up10 = 1; lap10 = 1; tick10 = 1;
    waitEdge;
    lap10 = 0; tick10 = 0;
    checks++; if (digit10 !== 4'd8) begin errors++; $display("[TB] FAIL rml_digit10: got %0d expected 8", digit10); end
    waitEdge;
    checks++; if (seg10 !== 7'h7F) begin errors++; $display("[TB] FAIL rml_lap_seg10: got %h expected 7f", seg10); end
    rst10 = 1; ss10 = 1; tick10 = 1;
    #1;
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL rml_running10_comb: got %b expected 0", running10); end
    waitEdge;
    rst10 = 0; ss10 = 0; tick10 = 0;
    checks++; if (digit10 !== 4'd0) begin errors++; $display("[TB] FAIL rml_digit10_after: got %0d expected 0", digit10); end
    checks++; if (running10 !== 1'b0) begin errors++; $display("[TB] FAIL rml_running10_after: got %b expected 0", running10); end
    checks++; if (seg10 !== 7'h7E) begin errors++; $display("[TB] FAIL rml_seg10_after: got %h expected 7e", seg10); end
    waitEdge;
    checks++; if (seg10 !== 7'h7E) begin errors++; $display("[TB] FAIL rml_seg10_idle: got %h expected 7e", seg10); end
  endtask

  initial begin
    rst6 = 1; tick6 = 0; up6 = 1; ss6 = 0; lap6 = 0; load6 = 0; loadVal6 = 4'd0;
    rst10 = 1; tick10 = 0; up10 = 1; ss10 = 0; lap10 = 0; load10 = 0; loadVal10 = 4'd0;
    test_reset;
    test_count_up_wrap;
    test_count_down_wrap;
    test_lap_freeze;
    test_clear_priority;
    test_load_clamp;
    test_reset_mid_lap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
